// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: control bundle between the fetch/decode/exec stages and pipe_ctrl.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] i_dec_rs1, i_dec_rs2, i_ex_rd;
  logic i_dec_uses_rs1, i_dec_uses_rs2, i_dec_is_md, i_ex_mem_r, i_ex_redirect, i_md_done;
  logic o_fetch_stall, o_dec_stall, o_dec_bubble, o_flush_fetch, o_flush_dec, o_md_start, o_md_err;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
  modport master (
    output i_dec_rs1, i_dec_rs2, i_ex_rd, i_dec_uses_rs1, i_dec_uses_rs2, i_dec_is_md,
           i_ex_mem_r, i_ex_redirect, i_md_done,
    input  o_fetch_stall, o_dec_stall, o_dec_bubble, o_flush_fetch, o_flush_dec, o_md_start,
           o_md_err, o_stall_cnt, o_flush_cnt
  );
  modport slave (
    input  i_dec_rs1, i_dec_rs2, i_ex_rd, i_dec_uses_rs1, i_dec_uses_rs2, i_dec_is_md,
           i_ex_mem_r, i_ex_redirect, i_md_done,
    output o_fetch_stall, o_dec_stall, o_dec_bubble, o_flush_fetch, o_flush_dec, o_md_start,
           o_md_err, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use stall, redirect flush and MUL/DIV sequencing for the front end.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input logic       i_clk,
  input logic       i_rst_n,
  pipe_ctrl_if.slave p
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int MW = $clog2(MD_TIMEOUT);
  typedef enum logic [1:0] {RUN, FLUSH, MD_WAIT} state_t;
  state_t st;
  logic [FW-1:0] flush_ctr;
  logic [MW-1:0] md_ctr;
  logic hazard, redir, haz_run, md_run, md_to, stall, flush;
  always_comb begin
    hazard  = p.i_ex_mem_r & (p.i_ex_rd != 6'd0) &
              ((p.i_dec_uses_rs1 & (p.i_dec_rs1 == p.i_ex_rd)) |
               (p.i_dec_uses_rs2 & (p.i_dec_rs2 == p.i_ex_rd)));
    redir   = (st == RUN) & p.i_ex_redirect;
    haz_run = (st == RUN) & ~p.i_ex_redirect & hazard;
    md_run  = (st == RUN) & ~p.i_ex_redirect & ~hazard & p.i_dec_is_md;
    md_to   = md_ctr == MW'(MD_TIMEOUT - 1);
    stall   = i_rst_n & (haz_run | md_run | ((st == MD_WAIT) & ~p.i_md_done & ~md_to));
    flush   = i_rst_n & ((st == FLUSH) | redir);
  end
  assign p.o_fetch_stall = stall;
  assign p.o_dec_stall   = stall;
  assign p.o_dec_bubble  = stall;
  assign p.o_flush_fetch = flush;
  assign p.o_flush_dec   = flush;
  assign p.o_md_start    = i_rst_n & md_run;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st            <= RUN;
      flush_ctr     <= '0;
      md_ctr        <= '0;
      p.o_md_err    <= 1'b0;
      p.o_stall_cnt <= '0;
      p.o_flush_cnt <= '0;
    end else begin
      if (stall && !(&p.o_stall_cnt)) p.o_stall_cnt <= p.o_stall_cnt + CNT_W'(1);
      if (p.i_ex_redirect && st != MD_WAIT && !(&p.o_flush_cnt)) p.o_flush_cnt <= p.o_flush_cnt + CNT_W'(1);
      case (st)
        RUN:
          if (p.i_ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              st        <= FLUSH;
              flush_ctr <= FW'(FLUSH_CYCLES - 1);
            end
          end else if (md_run) begin
            st     <= MD_WAIT;
            md_ctr <= '0;
          end
        FLUSH:
          if (p.i_ex_redirect) flush_ctr <= FW'(FLUSH_CYCLES - 1);
          else begin
            flush_ctr <= flush_ctr - FW'(1);
            if (flush_ctr == FW'(1)) st <= RUN;
          end
        MD_WAIT: begin
          md_ctr <= md_ctr + MW'(1);
          if (p.i_md_done) st <= RUN;
          else if (md_to) begin
            p.o_md_err <= 1'b1;
            st         <= RUN;
          end
        end
        default: st <= RUN;
      endcase
    end
  // exec only holds bubbles while an MD op is outstanding, so no redirect can arrive then
  a_no_redir_md: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(st == MD_WAIT && p.i_ex_redirect));
  a_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(stall && flush));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (A: FLUSH_CYCLES=2; B: MD_TIMEOUT=4, CNT_W=4).
module tb_pipe_ctrl;
  logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
  int tests = 0, fails = 0;
  int es_a = 0, ef_a = 0, es_b = 0, ef_b = 0;
  logic [5:0] sb[$];
  // output vector {flush_fetch, flush_dec, fetch_stall, dec_stall, dec_bubble, md_start}
  localparam logic [5:0] Z = 6'b000000, F = 6'b110000, S = 6'b001110, M = 6'b001111;
  // stimulus row {redir, mem_r, ex_rd, uses_rs1, rs1, uses_rs2, rs2, is_md, md_done}
  localparam logic [23:0] IDLE = 24'd0, RD = 24'h800000, MD = 24'd2, DN = 24'd1;
  localparam logic [23:0] HZ1 = {2'b01, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 2'b00};
  localparam logic [23:0] EXB = {2'b00, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 2'b00};
  localparam logic [23:0] X0  = {2'b01, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 2'b00};
  localparam logic [23:0] HZ2 = {2'b01, 6'd7, 1'b0, 6'd7, 1'b1, 6'd7, 2'b00};
  localparam logic [23:0] NOU = {2'b01, 6'd7, 1'b0, 6'd7, 1'b0, 6'd3, 2'b00};

  pipe_ctrl_if #(.CNT_W(32)) a();
  pipe_ctrl_if #(.CNT_W(4))  b();
  pipe_ctrl #(.FLUSH_CYCLES(2), .MD_TIMEOUT(64), .CNT_W(32)) dut_a (.i_clk(clk), .i_rst_n(rst_a), .p(a.slave));
  pipe_ctrl #(.FLUSH_CYCLES(1), .MD_TIMEOUT(4),  .CNT_W(4))  dut_b (.i_clk(clk), .i_rst_n(rst_b), .p(b.slave));

  always #5 clk = ~clk;

  task automatic apply(input bit sel_b, input logic [23:0] r);
    if (sel_b) {b.i_ex_redirect, b.i_ex_mem_r, b.i_ex_rd, b.i_dec_uses_rs1, b.i_dec_rs1,
                b.i_dec_uses_rs2, b.i_dec_rs2, b.i_dec_is_md, b.i_md_done} = r;
    else       {a.i_ex_redirect, a.i_ex_mem_r, a.i_ex_rd, a.i_dec_uses_rs1, a.i_dec_rs1,
                a.i_dec_uses_rs2, a.i_dec_rs2, a.i_dec_is_md, a.i_md_done} = r;
  endtask

  function automatic logic [5:0] outs(input bit sel_b);
    return sel_b ? {b.o_flush_fetch, b.o_flush_dec, b.o_fetch_stall, b.o_dec_stall, b.o_dec_bubble, b.o_md_start}
                 : {a.o_flush_fetch, a.o_flush_dec, a.o_fetch_stall, a.o_dec_stall, a.o_dec_bubble, a.o_md_start};
  endfunction

  task automatic test_reset();
    apply(0, RD | HZ1 | MD | DN);
    apply(1, RD | HZ1 | MD | DN);
    #2;
    tests++;
    if (outs(0) !== Z || outs(1) !== Z) begin
      fails++; $display("FAIL reset_outs got a=%b b=%b exp %b", outs(0), outs(1), Z);
    end
    tests++;
    if (a.o_stall_cnt !== 32'd0 || a.o_flush_cnt !== 32'd0 || b.o_stall_cnt !== 4'd0 || b.o_flush_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_cnt got %0d %0d %0d %0d exp 0", a.o_stall_cnt, a.o_flush_cnt, b.o_stall_cnt, b.o_flush_cnt);
    end
    tests++;
    if (a.o_md_err !== 1'b0 || b.o_md_err !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b %b exp 0", a.o_md_err, b.o_md_err);
    end
    apply(0, IDLE);
    apply(1, IDLE);
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic test_load_use();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{HZ1, EXB, IDLE, X0, HZ2, NOU, EXB, IDLE};
    expv = '{S,   Z,   Z,    Z,  S,   Z,   Z,   Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(0, stim[i]); sb.push_back(expv[i]);
      es_a += int'(expv[i][2]); ef_a += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(0) !== e) begin fails++; $display("FAIL load_use cyc%0d got %b exp %b", i, outs(0), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (a.o_stall_cnt !== 32'(es_a)) begin fails++; $display("FAIL load_use_cnt got %0d exp %0d", a.o_stall_cnt, es_a); end
  endtask

  task automatic test_flush();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{RD, IDLE, IDLE, IDLE, RD, RD, HZ1, IDLE, IDLE};
    expv = '{F,  F,    Z,    Z,    F,  F,  F,   Z,    Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(0, stim[i]); sb.push_back(expv[i]);
      es_a += int'(expv[i][2]); ef_a += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(0) !== e) begin fails++; $display("FAIL flush cyc%0d got %b exp %b", i, outs(0), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (a.o_flush_cnt !== 32'(ef_a)) begin fails++; $display("FAIL flush_cnt got %0d exp %0d", a.o_flush_cnt, ef_a); end
  endtask

  task automatic test_redirect_priority();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{RD | HZ1, IDLE, IDLE, RD | MD, IDLE, IDLE};
    expv = '{F,        F,    Z,    F,       F,    Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(0, stim[i]); sb.push_back(expv[i]);
      es_a += int'(expv[i][2]); ef_a += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(0) !== e) begin fails++; $display("FAIL redir_prio cyc%0d got %b exp %b", i, outs(0), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (a.o_flush_cnt !== 32'(ef_a) || a.o_stall_cnt !== 32'(es_a)) begin
      fails++; $display("FAIL redir_prio_cnt got %0d/%0d exp %0d/%0d", a.o_flush_cnt, a.o_stall_cnt, ef_a, es_a);
    end
  endtask

  task automatic test_md();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    int s0;
    s0 = es_a;
    stim = '{MD, IDLE, IDLE, IDLE, IDLE, IDLE, DN, DN, IDLE};
    expv = '{M,  S,    S,    S,    S,    S,    Z,  Z,  Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(0, stim[i]); sb.push_back(expv[i]);
      es_a += int'(expv[i][2]); ef_a += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(0) !== e) begin fails++; $display("FAIL md cyc%0d got %b exp %b", i, outs(0), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (a.o_stall_cnt !== 32'(s0 + 6) || a.o_md_err !== 1'b0) begin
      fails++; $display("FAIL md_cnt got %0d err %b exp %0d err 0", a.o_stall_cnt, a.o_md_err, s0 + 6);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{MD, MD | DN, MD, MD, DN, IDLE};
    expv = '{M,  Z,       M,  S,  Z,  Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(0, stim[i]); sb.push_back(expv[i]);
      es_a += int'(expv[i][2]); ef_a += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(0) !== e) begin fails++; $display("FAIL back_to_back cyc%0d got %b exp %b", i, outs(0), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (a.o_stall_cnt !== 32'(es_a)) begin fails++; $display("FAIL b2b_cnt got %0d exp %0d", a.o_stall_cnt, es_a); end
  endtask

  task automatic test_timeout();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{RD, IDLE, MD, IDLE, IDLE, IDLE, IDLE, IDLE};
    expv = '{F,  Z,    M,  S,    S,    S,    Z,    Z};
    for (int i = 0; i < stim.size(); i++) begin
      apply(1, stim[i]); sb.push_back(expv[i]);
      es_b += int'(expv[i][2]); ef_b += int'(stim[i][23]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(1) !== e) begin fails++; $display("FAIL timeout cyc%0d got %b exp %b", i, outs(1), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (b.o_md_err !== 1'b1) begin fails++; $display("FAIL md_err got %b exp 1", b.o_md_err); end
    tests++;
    if (b.o_stall_cnt !== 4'(es_b) || b.o_flush_cnt !== 4'(ef_b)) begin
      fails++; $display("FAIL timeout_cnt got %0d/%0d exp %0d/%0d", b.o_stall_cnt, b.o_flush_cnt, es_b, ef_b);
    end
  endtask

  task automatic test_reset_mid_md();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim = '{MD, IDLE};
    expv = '{M,  S};
    for (int i = 0; i < stim.size(); i++) begin
      apply(1, stim[i]); sb.push_back(expv[i]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(1) !== e) begin fails++; $display("FAIL mid_md cyc%0d got %b exp %b", i, outs(1), e); end
      @(posedge clk); #1;
    end
    rst_b = 1'b0;
    es_b = 0;
    ef_b = 0;
    #1;
    tests++;
    if (outs(1) !== Z || b.o_md_err !== 1'b0 || b.o_stall_cnt !== 4'd0 || b.o_flush_cnt !== 4'd0) begin
      fails++; $display("FAIL mid_md_reset got outs %b err %b cnt %0d/%0d exp 0", outs(1), b.o_md_err, b.o_stall_cnt, b.o_flush_cnt);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    stim = '{IDLE, HZ1};
    expv = '{Z,    S};
    for (int i = 0; i < stim.size(); i++) begin
      apply(1, stim[i]); sb.push_back(expv[i]);
      es_b += int'(expv[i][2]);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(1) !== e) begin fails++; $display("FAIL post_reset cyc%0d got %b exp %b", i, outs(1), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    logic [23:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    for (int i = 0; i < 20; i++) begin stim.push_back(HZ1); expv.push_back(S); end
    for (int i = 0; i < 20; i++) begin stim.push_back(RD); expv.push_back(F); end
    stim.push_back(IDLE); expv.push_back(Z);
    for (int i = 0; i < stim.size(); i++) begin
      apply(1, stim[i]); sb.push_back(expv[i]);
      if (expv[i][2] && es_b < 15) es_b++;
      if (stim[i][23] && ef_b < 15) ef_b++;
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (outs(1) !== e) begin fails++; $display("FAIL saturate cyc%0d got %b exp %b", i, outs(1), e); end
      @(posedge clk); #1;
    end
    tests++;
    if (b.o_stall_cnt !== 4'(es_b)) begin fails++; $display("FAIL stall_sat got %0d exp %0d", b.o_stall_cnt, es_b); end
    tests++;
    if (b.o_flush_cnt !== 4'(ef_b)) begin fails++; $display("FAIL flush_sat got %0d exp %0d", b.o_flush_cnt, ef_b); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_redirect_priority();
    test_md();
    test_back_to_back();
    test_timeout();
    test_reset_mid_md();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
